// File: rtl/stdp_if.sv
// stdp_if: bundles the spike, control and weight signals between a
// driver (master) and the stdp_ctrl learning controller (slave).
//   pre_spike, post_spike   : one-cycle spike pulses into the controller
//   learn_en                : enable STDP updates
//   weight_load, weight_in  : synchronous weight overwrite
//   weight, syn_current     : synaptic weight and gated post current
//   update_w_flag, time_diff: update pulse and dt of the last update
//   busy                    : pairing FSM is waiting for a partner spike
interface stdp_if #(
  parameter int W_WIDTH = 8,
  parameter int T_WIDTH = 3
);
  logic               pre_spike;
  logic               post_spike;
  logic               learn_en;
  logic               weight_load;
  logic [W_WIDTH-1:0] weight_in;
  logic [W_WIDTH-1:0] weight;
  logic [W_WIDTH-1:0] syn_current;
  logic               update_w_flag;
  logic [T_WIDTH-1:0] time_diff;
  logic               busy;

  modport master (
    output pre_spike, post_spike, learn_en, weight_load, weight_in,
    input  weight, syn_current, update_w_flag, time_diff, busy
  );

  modport slave (
    input  pre_spike, post_spike, learn_en, weight_load, weight_in,
    output weight, syn_current, update_w_flag, time_diff, busy
  );
endinterface

// File: rtl/stdp_ctrl.sv
// stdp_ctrl: STDP learning controller for one pre/post neuron pair.
// A three-state FSM (IDLE, PRE_WAIT, POST_WAIT) with a cycle counter
// measures the interval between a first spike and the opposite spike.
// Pre-then-post potentiates, post-then-pre depresses, by
// A_MAX >> (dt-1), saturating to [0, 2^W_WIDTH-1]. The registered
// syn_current drives the weight onto the post neuron when pre spikes.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : stdp_if slave modport (spikes, control, weight outputs)
// Optional feature, macro STDP_DECAY_EN: a DECAY_PERIOD counter that on
// each wrap nudges an idle weight one step toward W_INIT.
module stdp_ctrl #(
  parameter int W_WIDTH      = 8,
  parameter int W_INIT       = 32,
  parameter int A_MAX        = 16,
  parameter int WINDOW       = 4,
  parameter int T_WIDTH      = 3,
  parameter int DECAY_PERIOD = 64
) (
  input logic   clk,
  input logic   rst,
  stdp_if.slave bus
);

  // Elaboration-time sanity checks on the parameter set.
  if (WINDOW >= (1 << T_WIDTH)) begin : g_bad_window
    $error("T_WIDTH cannot hold WINDOW");
  end
  if (DECAY_PERIOD < 2) begin : g_bad_period
    $error("DECAY_PERIOD must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, PRE_WAIT, POST_WAIT} state_t;

  localparam logic [W_WIDTH-1:0] W_INIT_V   = W_WIDTH'(W_INIT);
  localparam logic [W_WIDTH:0]   A_MAX_V    = (W_WIDTH+1)'(A_MAX);
  localparam logic [T_WIDTH-1:0] WINDOW_V   = T_WIDTH'(WINDOW);
  localparam logic [T_WIDTH-1:0] CNT_ONE    = T_WIDTH'(1);

  state_t             state_reg, state_next;
  logic [T_WIDTH-1:0] cnt_reg, cnt_next;
  logic [W_WIDTH-1:0] weight_reg, weight_next;
  logic [W_WIDTH-1:0] syn_reg, syn_next;
  logic               flag_reg, flag_next;
  logic [T_WIDTH-1:0] td_reg, td_next;

  // Delta and saturated results are computed one bit wider so that the
  // carry/borrow bit flags overflow/underflow directly.
  logic [W_WIDTH:0]   delta;
  logic [W_WIDTH:0]   sum_ext;
  logic [W_WIDTH:0]   diff_ext;
  logic [W_WIDTH-1:0] ltp_w;
  logic [W_WIDTH-1:0] ltd_w;

  assign delta    = A_MAX_V >> (cnt_reg - CNT_ONE);
  assign sum_ext  = {1'b0, weight_reg} + delta;
  assign diff_ext = {1'b0, weight_reg} - delta;
  assign ltp_w    = sum_ext[W_WIDTH]  ? '1 : sum_ext[W_WIDTH-1:0];
  assign ltd_w    = diff_ext[W_WIDTH] ? '0 : diff_ext[W_WIDTH-1:0];

`ifdef STDP_DECAY_EN
  localparam int DC_W = $clog2(DECAY_PERIOD);
  localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECAY_PERIOD - 1);

  logic [DC_W-1:0] dcnt_reg;
  logic            decay_wrap;

  assign decay_wrap = (dcnt_reg == DC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt_reg <= '0;
    end else if (decay_wrap) begin
      dcnt_reg <= '0;
    end else begin
      dcnt_reg <= dcnt_reg + 1'b1;
    end
  end
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    weight_next = weight_reg;
    flag_next   = 1'b0;
    td_next     = td_reg;
    // Gate uses the pre-update weight of this cycle.
    syn_next    = bus.pre_spike ? weight_reg : '0;

    if (bus.weight_load) begin
      weight_next = bus.weight_in;
      state_next  = IDLE;
      cnt_next    = '0;
    end else if (!bus.learn_en) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Coincident spikes carry no timing information and are dropped.
          if (bus.pre_spike && !bus.post_spike) begin
            state_next = PRE_WAIT;
            cnt_next   = CNT_ONE;
          end else if (bus.post_spike && !bus.pre_spike) begin
            state_next = POST_WAIT;
            cnt_next   = CNT_ONE;
          end
        end
        PRE_WAIT: begin
          if (bus.post_spike) begin
            weight_next = ltp_w;
            flag_next   = 1'b1;
            td_next     = cnt_reg;
            state_next  = IDLE;
            cnt_next    = '0;
          end else if (bus.pre_spike) begin
            cnt_next = CNT_ONE;         // nearest-neighbour: newest pre wins
          end else if (cnt_reg == WINDOW_V) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        POST_WAIT: begin
          if (bus.pre_spike) begin
            weight_next = ltd_w;
            flag_next   = 1'b1;
            td_next     = cnt_reg;
            state_next  = IDLE;
            cnt_next    = '0;
          end else if (bus.post_spike) begin
            cnt_next = CNT_ONE;
          end else if (cnt_reg == WINDOW_V) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end

`ifdef STDP_DECAY_EN
    // Leak toward the resting weight only when nothing else touches it.
    if (decay_wrap && (state_reg == IDLE) && !bus.weight_load && !flag_next) begin
      if (weight_reg > W_INIT_V) begin
        weight_next = weight_reg - 1'b1;
      end else if (weight_reg < W_INIT_V) begin
        weight_next = weight_reg + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      weight_reg <= W_INIT_V;
      syn_reg    <= '0;
      flag_reg   <= 1'b0;
      td_reg     <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      weight_reg <= weight_next;
      syn_reg    <= syn_next;
      flag_reg   <= flag_next;
      td_reg     <= td_next;
    end
  end

  assign bus.weight        = weight_reg;
  assign bus.syn_current   = syn_reg;
  assign bus.update_w_flag = flag_reg;
  assign bus.time_diff     = td_reg;
  assign bus.busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_stdp_ctrl.sv
// tb_stdp_ctrl: directed scenarios with literal expectations, followed by
// randomized spike traffic. A timestamp-based pairing model predicts every
// output and a compare process checks the DUT after each rising edge.
module tb_stdp_ctrl;
  localparam int W_WIDTH      = 8;
  localparam int W_INIT       = 32;
  localparam int A_MAX        = 16;
  localparam int WINDOW       = 4;
  localparam int T_WIDTH      = 3;
  localparam int DECAY_PERIOD = 64;
  localparam int W_MAXV       = (1 << W_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst;

  stdp_if #(.W_WIDTH(W_WIDTH), .T_WIDTH(T_WIDTH)) bus ();

  stdp_ctrl #(
    .W_WIDTH(W_WIDTH), .W_INIT(W_INIT), .A_MAX(A_MAX),
    .WINDOW(WINDOW), .T_WIDTH(T_WIDTH), .DECAY_PERIOD(DECAY_PERIOD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remembers which spike is pending and when it arrived, and
  // derives dt as the difference of edge timestamps.
  int m_w, m_syn, m_flag, m_td, m_pend, m_anchor, m_dc, t_now;
  int w_old, dt, d;
  bit m_valid = 1'b0;
  bit was_idle, upd, opp, same, wrap;
  bit s_pre, s_post, s_learn, s_load;
  int s_win;

  always @(posedge clk) begin
    s_pre = bus.pre_spike;  s_post = bus.post_spike;
    s_learn = bus.learn_en; s_load = bus.weight_load;
    s_win = int'(bus.weight_in);
    t_now++;
    if (rst) begin
      m_w = W_INIT; m_syn = 0; m_flag = 0; m_td = 0; m_pend = 0; m_dc = 0;
      m_valid = 1'b1;
    end else begin
      w_old = m_w;
      was_idle = (m_pend == 0);
      upd = 1'b0;
      m_syn = s_pre ? w_old : 0;
      m_flag = 0;
      if (s_load) begin
        m_w = s_win; m_pend = 0;
      end else if (!s_learn) begin
        m_pend = 0;
      end else if (m_pend == 0) begin
        if (s_pre && !s_post) begin m_pend = 1; m_anchor = t_now; end
        else if (s_post && !s_pre) begin m_pend = 2; m_anchor = t_now; end
      end else begin
        dt = t_now - m_anchor;
        opp  = (m_pend == 1) ? s_post : s_pre;
        same = (m_pend == 1) ? s_pre : s_post;
        if (opp) begin
          d = A_MAX >> (dt - 1);
          if (m_pend == 1) m_w = (m_w + d > W_MAXV) ? W_MAXV : m_w + d;
          else             m_w = (m_w - d < 0) ? 0 : m_w - d;
          m_flag = 1; m_td = dt; m_pend = 0; upd = 1'b1;
        end else if (same) begin
          m_anchor = t_now;
        end else if (dt >= WINDOW) begin
          m_pend = 0;
        end
      end
`ifdef STDP_DECAY_EN
      wrap = (m_dc == DECAY_PERIOD - 1);
      m_dc = (m_dc + 1) % DECAY_PERIOD;
      if (wrap && was_idle && !upd && !s_load && m_w != W_INIT)
        m_w = (m_w < W_INIT) ? m_w + 1 : m_w - 1;
`else
      wrap = 1'b0;
`endif
    end
    #1;
    if (m_valid) begin
      check("weight",      int'(bus.weight),        m_w);
      check("syn_current", int'(bus.syn_current),   m_syn);
      check("update_flag", int'(bus.update_w_flag), m_flag);
      check("time_diff",   int'(bus.time_diff),     m_td);
      check("busy",        int'(bus.busy),          (m_pend != 0) ? 1 : 0);
    end
  end

  // Drive one cycle of inputs, then wait until the following falling edge.
  task automatic cyc(input bit pre, input bit post, input bit ld = 1'b0,
                     input int win = 0, input bit learn = 1'b1);
    bus.pre_spike   = pre;
    bus.post_spike  = post;
    bus.weight_load = ld;
    bus.weight_in   = W_WIDTH'(win);
    bus.learn_en    = learn;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  initial begin
    t_now = 0;
    rst = 1'b1;
    cyc(1'b1, 1'b1);
    rst = 1'b0;
    $display("txn reset: weight=%0d busy=%0d", bus.weight, bus.busy);
    check("rst_weight", int'(bus.weight), 32);
    check("rst_syn",    int'(bus.syn_current), 0);
    check("rst_flag",   int'(bus.update_w_flag), 0);
    check("rst_busy",   int'(bus.busy), 0);

    cyc(1'b1, 1'b0); idle(1); cyc(1'b0, 1'b1);
    $display("txn ltp dt=2: weight=%0d time_diff=%0d", bus.weight, bus.time_diff);
    check("ltp_weight", int'(bus.weight), 40);
    check("ltp_td",     int'(bus.time_diff), 2);
    check("ltp_flag",   int'(bus.update_w_flag), 1);
    check("ltp_busy",   int'(bus.busy), 0);
    idle(1);
    check("ltp_flag_drop", int'(bus.update_w_flag), 0);

    cyc(1'b0, 1'b0, 1'b1, 32); cyc(1'b0, 1'b1); cyc(1'b1, 1'b0);
    $display("txn ltd dt=1: weight=%0d time_diff=%0d", bus.weight, bus.time_diff);
    check("ltd_weight", int'(bus.weight), 16);
    check("ltd_td",     int'(bus.time_diff), 1);
    check("ltd_syn_old", int'(bus.syn_current), 32);
    cyc(1'b1, 1'b0);
    $display("txn syn gate: syn_current=%0d", bus.syn_current);
    check("syn_gate", int'(bus.syn_current), 16);
    idle(4);
    check("pre_timeout_busy", int'(bus.busy), 0);

    cyc(1'b0, 1'b0, 1'b1, 250); cyc(1'b1, 1'b0); cyc(1'b0, 1'b1);
    $display("txn sat high: weight=%0d", bus.weight);
    check("sat_high", int'(bus.weight), 255);
    cyc(1'b0, 1'b0, 1'b1, 3); cyc(1'b0, 1'b1); idle(1); cyc(1'b1, 1'b0);
    $display("txn sat low: weight=%0d", bus.weight);
    check("sat_low",    int'(bus.weight), 0);
    check("sat_low_td", int'(bus.time_diff), 2);

    cyc(1'b0, 1'b0, 1'b1, 100); cyc(1'b1, 1'b0); idle(4); cyc(1'b0, 1'b1);
    $display("txn timeout dt=5: weight=%0d busy=%0d", bus.weight, bus.busy);
    check("to_weight", int'(bus.weight), 100);
    check("to_flag",   int'(bus.update_w_flag), 0);
    check("to_busy",   int'(bus.busy), 1);
    idle(4);

    cyc(1'b1, 1'b1);
    $display("txn coincident: busy=%0d", bus.busy);
    check("coin_busy", int'(bus.busy), 0);
    check("coin_flag", int'(bus.update_w_flag), 0);

    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
    $display("txn learn off: weight=%0d", bus.weight);
    check("nolearn_weight", int'(bus.weight), 100);
    check("nolearn_busy",   int'(bus.busy), 0);

    cyc(1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b1, 77);
    $display("txn load vs ltp: weight=%0d flag=%0d", bus.weight, bus.update_w_flag);
    check("load_weight", int'(bus.weight), 77);
    check("load_flag",   int'(bus.update_w_flag), 0);
    check("load_busy",   int'(bus.busy), 0);

`ifdef STDP_DECAY_EN
    cyc(1'b0, 1'b0, 1'b1, 34); idle(128);
    $display("txn decay: weight=%0d", bus.weight);
    check("decay_weight", int'(bus.weight), 32);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 63) == 0, int'($urandom_range(0, 255)),
          $urandom_range(0, 15) != 0);
      if (bus.update_w_flag)
        $display("txn rand update: weight=%0d time_diff=%0d", bus.weight, bus.time_diff);
    end
    rst = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
